// File: rtl/adas_sensor_scheduler_if.sv
// Sensor handshake and fused-distance signals of the ADAS distance scheduler.
// master = scheduler side, slave = sensors / downstream consumer side.
interface adas_sensor_scheduler_if;
  logic       enable_i;
  logic       lidar_req_o;
  logic       lidar_vld_i;
  logic [7:0] lidar_data_i;
  logic       cam_req_o;
  logic       cam_vld_i;
  logic [7:0] cam_data_i;
  logic [7:0] distance_o;
  logic       distance_vld_o;
  logic [1:0] sensor_status_o;
  logic       fault_o;

  modport master (
    input  enable_i,
    input  lidar_vld_i,
    input  lidar_data_i,
    input  cam_vld_i,
    input  cam_data_i,
    output lidar_req_o,
    output cam_req_o,
    output distance_o,
    output distance_vld_o,
    output sensor_status_o,
    output fault_o
  );

  modport slave (
    output enable_i,
    output lidar_vld_i,
    output lidar_data_i,
    output cam_vld_i,
    output cam_data_i,
    input  lidar_req_o,
    input  cam_req_o,
    input  distance_o,
    input  distance_vld_o,
    input  sensor_status_o,
    input  fault_o
  );
endinterface

// File: rtl/adas_sensor_scheduler.sv
// Periodic lidar/camera sampling round with timeout, fused into one 8-bit distance.
// distance_vld_o is the round tick consumed by the downstream distance/brake logic.
//
// state     | meaning
// S_IDLE    | waiting for a period wrap while enabled
// S_COLLECT | reqs outstanding, capturing samples until both done or timeout
// S_FUSE    | one cycle: publish fused distance, status, fault and the tick pulse
module adas_sensor_scheduler #(
  parameter int unsigned TICK_PERIOD = 1000,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned DIFF_LIMIT  = 20
) (
  input logic                     clk,
  input logic                     rst_n,
  adas_sensor_scheduler_if.master bus
);

  localparam int unsigned   PW        = $clog2(TICK_PERIOD);
  localparam int unsigned   TW        = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_PERIOD - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    DIFF_LIM  = 8'(DIFF_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FUSE    = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] pcnt_q;
  logic [TW-1:0] tcnt_q;
  logic          lidar_req_q;
  logic          cam_req_q;
  logic          lidar_done_q;
  logic          cam_done_q;
  logic [7:0]    lidar_data_q;
  logic [7:0]    cam_data_q;
  logic [7:0]    distance_q;
  logic          distance_vld_q;
  logic [1:0]    status_q;
  logic          fault_q;

  logic          round_start;
  logic          lidar_cap;
  logic          cam_cap;
  logic          lidar_done_d;
  logic          cam_done_d;
  logic          collect_exit;
  logic [7:0]    diff_d;
  logic [8:0]    sum_d;
  logic [7:0]    fused_d;

  // Period counter is free-running only while enabled, so the first round
  // always comes a full period after enable rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (!bus.enable_i) begin
      pcnt_q <= '0;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PW'(1);
    end
  end

  assign round_start = bus.enable_i && (pcnt_q == PCNT_LAST);

  assign lidar_cap    = (state_q == S_COLLECT) && lidar_req_q && !lidar_done_q && bus.lidar_vld_i;
  assign cam_cap      = (state_q == S_COLLECT) && cam_req_q && !cam_done_q && bus.cam_vld_i;
  assign lidar_done_d = lidar_done_q | lidar_cap;
  assign cam_done_d   = cam_done_q | cam_cap;
  assign collect_exit = (lidar_done_d && cam_done_d) || (tcnt_q == TCNT_LAST);

  // Large disagreement trusts lidar; otherwise average with a 9-bit sum.
  always_comb begin
    diff_d  = (lidar_data_q >= cam_data_q) ? (lidar_data_q - cam_data_q)
                                           : (cam_data_q - lidar_data_q);
    sum_d   = {1'b0, lidar_data_q} + {1'b0, cam_data_q};
    fused_d = distance_q;
    case ({lidar_done_q, cam_done_q})
      2'b11:   fused_d = (diff_d > DIFF_LIM) ? lidar_data_q : 8'(sum_d >> 1);
      2'b10:   fused_d = lidar_data_q;
      2'b01:   fused_d = cam_data_q;
      default: fused_d = distance_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tcnt_q         <= '0;
      lidar_req_q    <= 1'b0;
      cam_req_q      <= 1'b0;
      lidar_done_q   <= 1'b0;
      cam_done_q     <= 1'b0;
      lidar_data_q   <= '0;
      cam_data_q     <= '0;
      distance_q     <= '0;
      distance_vld_q <= 1'b0;
      status_q       <= '0;
      fault_q        <= 1'b0;
    end else begin
      distance_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (round_start) begin
            state_q      <= S_COLLECT;
            lidar_req_q  <= 1'b1;
            cam_req_q    <= 1'b1;
            lidar_done_q <= 1'b0;
            cam_done_q   <= 1'b0;
            tcnt_q       <= '0;
          end
        end
        S_COLLECT: begin
          tcnt_q       <= tcnt_q + TW'(1);
          lidar_done_q <= lidar_done_d;
          cam_done_q   <= cam_done_d;
          if (lidar_cap) begin
            lidar_data_q <= bus.lidar_data_i;
            lidar_req_q  <= 1'b0;
          end
          if (cam_cap) begin
            cam_data_q <= bus.cam_data_i;
            cam_req_q  <= 1'b0;
          end
          if (collect_exit) begin
            state_q     <= S_FUSE;
            lidar_req_q <= 1'b0;
            cam_req_q   <= 1'b0;
          end
        end
        S_FUSE: begin
          distance_q     <= fused_d;
          status_q       <= {lidar_done_q, cam_done_q};
          fault_q        <= !(lidar_done_q || cam_done_q);
          distance_vld_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lidar_req_o     = lidar_req_q;
  assign bus.cam_req_o       = cam_req_q;
  assign bus.distance_o      = distance_q;
  assign bus.distance_vld_o  = distance_vld_q;
  assign bus.sensor_status_o = status_q;
  assign bus.fault_o         = fault_q;

endmodule
